affine_nsh_ser: RTL and testbench



---
 rtl/affine_nsh_pkg.sv | 27 ++
 rtl/affine_nsh_nib.sv | 17 +
 rtl/affine_nsh_ser.sv | 119 +++++++++++
 tb/tb_affine_nsh_ser.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/affine_nsh_pkg.sv
// affine_nsh_pkg: shared constants and types for the serialised masked affine layer.
// A is stored as four row masks: output bit i = parity(AFF_A[i] & x).
// A is unit upper-triangular, so the map is invertible.
package affine_nsh_pkg;

   typedef logic [3:0] nib_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Rows of A, row 0 in the low nibble.
   localparam logic [3:0][3:0] AFF_A = {4'b1000, 4'b1100, 4'b0110, 4'b1011};
   localparam nib_t            AFF_C = 4'hA;

   // Linear part A*x over GF(2).
   function automatic nib_t aff_lin(input nib_t x);
      nib_t r;
      for (int i = 0; i < 4; i++) begin
         r[i] = ^(AFF_A[i] & x);
      end
      return r;
   endfunction

endpackage

// File: rtl/affine_nsh_nib.sv
// affine_nsh_nib: one 4-bit share map. ADD_CONST=1 gives A*x ^ C (share 0),
// ADD_CONST=0 gives the purely linear A*x used by every other share.
module affine_nsh_nib
   import affine_nsh_pkg::*;
#(
   parameter bit ADD_CONST = 1'b0
) (
   input  logic [3:0] x,
   output logic [3:0] y
);

   // Affine map of a single nibble of a single share.
   always_comb begin
      y = aff_lin(x) ^ (ADD_CONST ? AFF_C : 4'h0);
   end

endmodule

// File: rtl/affine_nsh_ser.sv
// affine_nsh_ser: serialised affine layer over a Boolean-shared state.
// Captures all shares, transforms LANES nibbles of every share per cycle in
// place, then presents the result until the consumer takes it.
// Each nibble lane reads exactly one share, so shares never mix.
// Build option: define AFFINE_NSH_SER_CLR_EN to wipe the result register after
// the output handshake and force out_data to zero while out_valid is low.
module affine_nsh_ser
   import affine_nsh_pkg::*;
#(
   parameter int SHARES  = 3,
   parameter int NIBBLES = 16,
   parameter int LANES   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SHARES*4*NIBBLES-1:0]   in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SHARES*4*NIBBLES-1:0]   out_data
);

   localparam int STEPS = NIBBLES / LANES;
   localparam int CW    = (STEPS > 1)   ? $clog2(STEPS)   : 1;
   localparam int KW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t                            st, st_nx;
   logic [CW-1:0]                     cnt;
   nib_t [SHARES-1:0][NIBBLES-1:0]    data_q, data_nx;
   nib_t [SHARES-1:0][LANES-1:0]      lane_y;
   logic                              last;

   // Nibble index handled by lane 'lane' in step 'c'.
   function automatic logic [KW-1:0] nib_idx(input logic [CW-1:0] c, input int lane);
      return KW'(int'(c) * LANES + lane);
   endfunction

   assign last = (cnt == CW'(STEPS - 1));

   // One map per lane per share; share 0 carries the constant.
   for (genvar s = 0; s < SHARES; s++) begin : g_share
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         affine_nsh_nib #(.ADD_CONST(s == 0)) u_nib (
            .x (data_q[s][nib_idx(cnt, l)]),
            .y (lane_y[s][l])
         );
      end
   end

   // Merge the transformed lanes back into their slots of the state.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      data_nx = data_q;
      for (int s = 0; s < SHARES; s++) begin
         for (int l = 0; l < LANES; l++) begin
            data_nx[s][nib_idx(cnt, l)] = lane_y[s][l];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      if (rst) st <= IDLE;
      else     st <= st_nx;
   end

   // FSM next-state logic.
   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    if (in_valid)  st_nx = BUSY;
         BUSY:    if (last)      st_nx = DONE;
         DONE:    if (out_ready) st_nx = IDLE;
         default:                st_nx = IDLE;
      endcase
   end

   // FSM outputs; result visibility depends on the clear-on-handoff option.
   always_comb begin
      in_ready  = (st == IDLE);
      out_valid = (st == DONE);
`ifdef AFFINE_NSH_SER_CLR_EN
      out_data  = out_valid ? data_q : '0;
`else
      out_data  = data_q;
`endif
   end

   // Datapath: capture, in-place serial transform, step counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the wide state register is reset because its contents are visible on out_data.
         data_q <= '0;
         cnt    <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (in_valid) begin
                  data_q <= in_data;
                  cnt    <= '0;
               end
            end
            BUSY: begin
               data_q <= data_nx;
               cnt    <= last ? '0 : cnt + 1'b1;
            end
            DONE: begin
`ifdef AFFINE_NSH_SER_CLR_EN
               if (out_ready) data_q <= '0;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_affine_nsh_ser.sv
// tb_affine_nsh_ser: scoreboard bench for three affine_nsh_ser configurations
// (3 shares/16 nibbles/4 lanes, 2/8/2, 4/16/16). Expected results come from a
// column-wise GF(2) model of A and nibble-level recombination of shares.
module tb_affine_nsh_ser;

   localparam int ND = 3;
   localparam int MW = 256;

   // Columns of A: A*x = XOR of COL[j] over set bits j of x.
   localparam logic [3:0] A_COL [4] = '{4'h1, 4'h3, 4'h6, 4'hD};
   localparam logic [3:0] C_REF     = 4'hA;

   function automatic int sh_of(input int d);
      case (d)
         0:       return 3;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int nb_of(input int d);
      return (d == 1) ? 8 : 16;
   endfunction

   function automatic int ln_of(input int d);
      case (d)
         0:       return 4;
         1:       return 2;
         default: return 16;
      endcase
   endfunction

   logic                  clk = 1'b0;
   logic                  rst;
   logic [ND-1:0]         in_valid;
   logic [MW-1:0]         in_data [ND];
   logic [ND-1:0]         in_ready_w, out_valid_w;
   logic [ND-1:0][MW-1:0] out_data_w;
   logic                  rdy_rand;
   logic [ND-1:0]         rdy_fix, rnd_bit;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [MW-1:0] data;
      logic [63:0]   secret;
      longint        t_exp;
   } exp_t;

   exp_t          exp_q [ND][$];
   logic [MW-1:0] last_exp [ND];

   always #5 clk = ~clk;

   // Fresh random ready pattern every cycle for the random phase.
   always @(negedge clk) rnd_bit = ND'($urandom);

   task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] amul(input logic [3:0] x);
      logic [3:0] r = 4'h0;
      for (int j = 0; j < 4; j++) if (x[j]) r ^= A_COL[j];
      return r;
   endfunction

   // Expected packed output: every nibble of every share through A, C on share 0.
   function automatic logic [MW-1:0] model(input int d, input logic [MW-1:0] v);
      logic [MW-1:0] r = '0;
      for (int s = 0; s < sh_of(d); s++)
         for (int k = 0; k < nb_of(d); k++)
            r[(s*nb_of(d)+k)*4 +: 4] = amul(v[(s*nb_of(d)+k)*4 +: 4]) ^ ((s == 0) ? C_REF : 4'h0);
      return r;
   endfunction

   // Nibble-wise XOR of all shares.
   function automatic logic [63:0] recombine(input int d, input logic [MW-1:0] v);
      logic [63:0] r = '0;
      for (int s = 0; s < sh_of(d); s++)
         for (int k = 0; k < nb_of(d); k++)
            r[4*k +: 4] ^= v[(s*nb_of(d)+k)*4 +: 4];
      return r;
   endfunction

   // Unshared affine result of a secret.
   function automatic logic [63:0] secret_map(input int d, input logic [63:0] x);
      logic [63:0] r = '0;
      for (int k = 0; k < nb_of(d); k++) r[4*k +: 4] = amul(x[4*k +: 4]) ^ C_REF;
      return r;
   endfunction

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int SH = sh_of(g);
      localparam int NB = nb_of(g);
      localparam int LN = ln_of(g);
      localparam int W  = SH * 4 * NB;

      logic [W-1:0]  od;
      logic          ordy;
      logic          prev_v = 1'b0;
      logic [MW-1:0] held = '0;

      assign ordy          = rdy_rand ? rnd_bit[g] : rdy_fix[g];
      assign out_data_w[g] = MW'(od);

      affine_nsh_ser #(.SHARES(SH), .NIBBLES(NB), .LANES(LN)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready_w[g]),
         .in_data   (in_data[g][W-1:0]),
         .out_valid (out_valid_w[g]),
         .out_ready (ordy),
         .out_data  (od)
      );

      // Monitor: pop and compare on each rising out_valid, check hold otherwise.
      always @(negedge clk) begin
         exp_t e;
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (out_valid_w[g] && !prev_v) begin
               if (exp_q[g].size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL dut%0d unexpected out_valid: got data %h expected none", g, out_data_w[g]);
               end else begin
                  e = exp_q[g].pop_front();
                  check($sformatf("dut%0d data", g), out_data_w[g], e.data);
                  check($sformatf("dut%0d latency", g), MW'($time), MW'(e.t_exp));
                  check($sformatf("dut%0d xor", g), MW'(recombine(g, out_data_w[g])), MW'(secret_map(g, e.secret)));
               end
               held = out_data_w[g];
            end else if (out_valid_w[g]) begin
               check($sformatf("dut%0d hold", g), out_data_w[g], held);
            end
            prev_v = out_valid_w[g];
         end
      end
   end

   // Present one transaction; returns just after the accepting edge.
   task automatic send(input int d, input logic [MW-1:0] v, input logic [63:0] secret,
                       input logic [MW-1:0] expv);
      exp_t e;
      int   waited = 0;
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_data[d]  = v;
      while (!in_ready_w[d]) begin
         @(negedge clk);
         waited++;
         if (waited > 200) begin
            tests++;
            fails++;
            $display("FAIL dut%0d in_ready timeout: got 0 expected 1", d);
            in_valid[d] = 1'b0;
            return;
         end
      end
      e.data   = expv;
      e.secret = secret;
      e.t_exp  = $time + longint'((nb_of(d) / ln_of(d) + 1) * 10);
      exp_q[d].push_back(e);
      last_exp[d] = expv;
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_data[d]  = {8{$urandom}};
   endtask

   // Random sharing of a random secret.
   task automatic make_sharing(input int d, output logic [MW-1:0] v, output logic [63:0] secret);
      logic [63:0] mask, acc, r;
      mask   = (64'd1 << (4 * nb_of(d))) - 64'd1;
      secret = {$urandom, $urandom} & mask;
      acc    = secret;
      v      = '0;
      for (int s = 1; s < sh_of(d); s++) begin
         r    = {$urandom, $urandom} & mask;
         acc ^= r;
         for (int k = 0; k < nb_of(d); k++) v[(s*nb_of(d)+k)*4 +: 4] = r[4*k +: 4];
      end
      for (int k = 0; k < nb_of(d); k++) v[k*4 +: 4] = acc[4*k +: 4];
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      while (exp_q[d].size() != 0 || !in_ready_w[d]) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            tests++;
            fails++;
            $display("FAIL dut%0d drain timeout: got %0d pending expected 0", d, exp_q[d].size());
            exp_q[d].delete();
            return;
         end
      end
   endtask

   task automatic wait_valid(input int d, output bit ok);
      int n = 0;
      ok = 1'b1;
      while (!out_valid_w[d]) begin
         @(negedge clk);
         n++;
         if (n > 100) begin
            tests++;
            fails++;
            $display("FAIL dut%0d out_valid timeout: got 0 expected 1", d);
            ok = 1'b0;
            return;
         end
      end
   endtask

   // After the handshake: out_valid low, out_data retained or cleared.
   task automatic post_handshake(input int d);
      logic [MW-1:0] exp_after;
`ifdef AFFINE_NSH_SER_CLR_EN
      exp_after = '0;
`else
      exp_after = last_exp[d];
`endif
      @(negedge clk);
      check($sformatf("dut%0d valid after handshake", d), MW'(out_valid_w[d]), MW'(1'b0));
      check($sformatf("dut%0d data after handshake", d), out_data_w[d], exp_after);
   endtask

   task automatic rand_stream(input int d, input int n);
      logic [MW-1:0] v;
      logic [63:0]   x;
      for (int i = 0; i < n; i++) begin
         make_sharing(d, v, x);
         send(d, v, x, model(d, v));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_idle(d);
   endtask

   initial begin
      logic [MW-1:0] v;
      logic [63:0]   x;
      bit            ok;
      int            stale;

      rst      = 1'b1;
      in_valid = '0;
      rdy_rand = 1'b0;
      rdy_fix  = '1;
      for (int d = 0; d < ND; d++) in_data[d] = '0;

      // Reset state.
      #12;
      for (int d = 0; d < ND; d++) begin
         check($sformatf("dut%0d reset in_ready", d),  MW'(in_ready_w[d]),  MW'(1'b1));
         check($sformatf("dut%0d reset out_valid", d), MW'(out_valid_w[d]), MW'(1'b0));
         check($sformatf("dut%0d reset out_data", d),  out_data_w[d],       '0);
      end
      @(negedge clk);
      rst = 1'b0;

      // All-zero shares: share 0 becomes C everywhere, other shares stay zero.
      send(0, '0, 64'h0, MW'({128'h0, {16{4'hA}}}));
      wait_idle(0);

      // Consumer stalls in DONE; in_valid pulses are ignored throughout.
      rdy_fix[0] = 1'b0;
      make_sharing(0, v, x);
      send(0, v, x, model(0, v));
      while (!out_valid_w[0] && ok) begin
         in_valid[0] = 1'($urandom_range(0, 1));
         in_data[0]  = {8{$urandom}};
         check("dut0 in_ready busy", MW'(in_ready_w[0]), MW'(1'b0));
         @(negedge clk);
      end
      wait_valid(0, ok);
      repeat (7) begin
         in_valid[0] = 1'($urandom_range(0, 1));
         in_data[0]  = {8{$urandom}};
         @(negedge clk);
         check("dut0 in_ready done", MW'(in_ready_w[0]), MW'(1'b0));
         check("dut0 out_valid held", MW'(out_valid_w[0]), MW'(1'b1));
      end
      in_valid[0] = 1'b0;
      rdy_fix[0]  = 1'b1;
      post_handshake(0);

      // Reset in the second BUSY cycle abandons the transaction.
      make_sharing(0, v, x);
      send(0, v, x, model(0, v));
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("dut0 mid-reset in_ready",  MW'(in_ready_w[0]),  MW'(1'b1));
      check("dut0 mid-reset out_valid", MW'(out_valid_w[0]), MW'(1'b0));
      check("dut0 mid-reset out_data",  out_data_w[0],       '0);
      exp_q[0].delete();
      @(negedge clk);
      rst   = 1'b0;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid_w[0]) stale++;
      end
      check("dut0 no stale out_valid", MW'(stale), '0);
      make_sharing(0, v, x);
      send(0, v, x, model(0, v));
      wait_idle(0);

      // Single-step configuration and its post-handshake view.
      make_sharing(2, v, x);
      send(2, v, x, model(2, v));
      wait_valid(2, ok);
      if (ok) post_handshake(2);
      wait_idle(2);

      // Random sharings on all three configurations with random back-pressure.
      rdy_rand = 1'b1;
      fork
         rand_stream(0, 1000);
         rand_stream(1, 1000);
         rand_stream(2, 1000);
      join

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
